// File: rtl/matrix_stream_port.sv
// Byte-stream host port for a 3x3 combinational multiplier: loads A then B, waits for the product to settle, then streams the result out.
// Latency: first result byte is valid SETTLE_CYCLES+1 cycles after the last operand byte is accepted.
// Backpressure: in_ready drops outside LOAD_A/LOAD_B; out_data/out_valid are held while out_ready is low. Optional: MATRIX_STREAM_PORT_CHECKSUM_EN.
module matrix_stream_port #(
    parameter int R1            = 3,
    parameter int K1            = 3,
    parameter int K2            = 3,
    parameter int W             = 8,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                CLOCK_50,
    input  logic                RESET_N,
    input  logic [W-1:0]        in_data,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [R1*K1*W-1:0]  niz1,
    output logic [K1*K2*W-1:0]  niz2,
    input  logic [R1*K2*W-1:0]  niz,
    output logic [W-1:0]        out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                busy,
    output logic                done
);

    localparam int NA = R1 * K1;
    localparam int NB = K1 * K2;
    localparam int NR = R1 * K2;
`ifdef MATRIX_STREAM_PORT_CHECKSUM_EN
    localparam int NOUT = NR + 1;
`else
    localparam int NOUT = NR;
`endif
    localparam int NAB  = (NA > NB) ? NA : NB;
    localparam int NMAX = (NAB > NOUT) ? NAB : NOUT;
    localparam int IW   = $clog2(NMAX + 1);
    localparam int CW   = 4;

    typedef enum logic [1:0] {
        LOAD_A = 2'd0,
        LOAD_B = 2'd1,
        SETTLE = 2'd2,
        SEND   = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [IW-1:0]      r_idx;
    logic [IW-1:0]      w_idx_nxt;
    logic [CW-1:0]      r_cnt;
    logic [CW-1:0]      w_cnt_nxt;
    logic               r_in_rdy;
    logic               r_out_vld;
    logic               w_out_vld_nxt;
    logic               r_done;
    logic               w_done_nxt;
    logic               w_capture;
    logic               w_in_xfer;
    logic               w_out_xfer;
    logic [R1*K1*W-1:0] r_niz1;
    logic [K1*K2*W-1:0] r_niz2;
    logic [R1*K2*W-1:0] r_snap;
    logic [W-1:0]       w_out_dat;

    assign w_in_xfer  = in_valid & r_in_rdy;
    assign w_out_xfer = r_out_vld & out_ready;

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state   <= LOAD_A;
            r_idx     <= '0;
            r_cnt     <= '0;
            r_in_rdy  <= 1'b0;
            r_out_vld <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_idx     <= w_idx_nxt;
            r_cnt     <= w_cnt_nxt;
            r_in_rdy  <= (w_state_nxt == LOAD_A) || (w_state_nxt == LOAD_B);
            r_out_vld <= w_out_vld_nxt;
            r_done    <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_idx_nxt     = r_idx;
        w_cnt_nxt     = r_cnt;
        w_out_vld_nxt = r_out_vld;
        w_done_nxt    = 1'b0;
        w_capture     = 1'b0;
        case (r_state)
            LOAD_A: begin
                if (w_in_xfer) begin
                    if (r_idx == IW'(NA - 1)) begin
                        w_idx_nxt   = '0;
                        w_state_nxt = LOAD_B;
                    end else begin
                        w_idx_nxt = r_idx + 1'b1;
                    end
                end
            end
            LOAD_B: begin
                if (w_in_xfer) begin
                    if (r_idx == IW'(NB - 1)) begin
                        w_idx_nxt   = '0;
                        w_cnt_nxt   = '0;
                        w_state_nxt = SETTLE;
                    end else begin
                        w_idx_nxt = r_idx + 1'b1;
                    end
                end
            end
            SETTLE: begin
                w_cnt_nxt = r_cnt + 1'b1;
                if (r_cnt == CW'(SETTLE_CYCLES - 1)) begin
                    w_capture   = 1'b1;
                    w_state_nxt = SEND;
                end
            end
            SEND: begin
                // First SEND cycle only presents the snapshot; transfers start once out_valid is up.
                if (!r_out_vld) begin
                    w_out_vld_nxt = 1'b1;
                end else if (w_out_xfer) begin
                    if (r_idx == IW'(NOUT - 1)) begin
                        w_idx_nxt     = '0;
                        w_out_vld_nxt = 1'b0;
                        w_done_nxt    = 1'b1;
                        w_state_nxt   = LOAD_A;
                    end else begin
                        w_idx_nxt = r_idx + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = LOAD_A;
                w_idx_nxt   = '0;
            end
        endcase
    end

`ifdef MATRIX_STREAM_PORT_CHECKSUM_EN
    logic [W-1:0] r_csum;
    logic [W-1:0] w_csum;

    always_comb begin
        w_csum = '0;
        for (int e = 0; e < NR; e++) begin
            w_csum = w_csum + niz[e*W +: W];
        end
    end
`endif

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_niz1 <= '0;
            r_niz2 <= '0;
            r_snap <= '0;
`ifdef MATRIX_STREAM_PORT_CHECKSUM_EN
            r_csum <= '0;
`endif
        end else begin
            if (r_state == LOAD_A && w_in_xfer) begin
                r_niz1[int'(r_idx)*W +: W] <= in_data;
            end
            if (r_state == LOAD_B && w_in_xfer) begin
                r_niz2[int'(r_idx)*W +: W] <= in_data;
            end
            if (w_capture) begin
                r_snap <= niz;
`ifdef MATRIX_STREAM_PORT_CHECKSUM_EN
                r_csum <= w_csum;
`endif
            end
        end
    end

    always_comb begin
        w_out_dat = r_snap[int'(r_idx)*W +: W];
`ifdef MATRIX_STREAM_PORT_CHECKSUM_EN
        if (r_idx == IW'(NR)) begin
            w_out_dat = r_csum;
        end
`endif
    end

    assign niz1      = r_niz1;
    assign niz2      = r_niz2;
    assign in_ready  = r_in_rdy;
    assign out_valid = r_out_vld;
    assign out_data  = r_out_vld ? w_out_dat : '0;
    assign done      = r_done;
    assign busy      = !((r_state == LOAD_A) && (r_idx == '0));

endmodule
